mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL provide parameter LATENCY, default 4, cycles from request acceptance to response presentation (legal 1..7).
REQ-002 SHALL provide parameter ADDR_W, default 16, byte-address width.
REQ-003 SHALL provide parameter DATA_W, default 16, word width.
REQ-004 SHALL provide parameter DEPTH, default 1024, number of words in the array.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  1  initiator presents a request.
REQ-008 req_ready  out  1  responder can accept a request this cycle.
REQ-009 req_wr  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  byte address; word index = req_addr[ADDR_W-1:1] mod DEPTH.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 resp_valid  out  1  response presented.
REQ-013 resp_ready  in  1  initiator consumes the response.
REQ-014 resp_rdata  out  DATA_W  read data; 0 for writes.
REQ-015 resp_wr  out  1  echo of req_wr for this response.
REQ-016 resp_err  out  1  misalignment error (see REQ-031).
REQ-017 inflight  out  3  count of accepted requests not yet consumed.

Function
REQ-018 A request SHALL be accepted on a rising edge where req_valid & req_ready.
REQ-019 req_ready SHALL equal ~(resp_valid & ~resp_ready), so the block never drops a response.
REQ-020 Writes SHALL update the array on the accepting edge. Reads SHALL sample the array on the accepting edge.
REQ-021 A read accepted one cycle after a write to the same word SHALL return the new data.
REQ-022 Every accepted request SHALL produce exactly one response, in acceptance order, with resp_valid rising exactly LATENCY cycles after acceptance when there is no stall.
REQ-023 The pipeline SHALL be LATENCY stages deep, each stage holding {valid, wr, err, data}, and SHALL accept one request per cycle at full throughput.
REQ-024 When resp_valid=1 and resp_ready=0, all stages SHALL freeze, resp_* SHALL hold stable, and no request SHALL be accepted.
REQ-025 A response SHALL be consumed on an edge where resp_valid & resp_ready.
REQ-026 inflight SHALL increment on accept and decrement on consume. Simultaneous accept and consume SHALL leave it unchanged. It SHALL saturate at LATENCY and never wrap.
REQ-027 When resp_valid=0, resp_rdata, resp_wr and resp_err SHALL be 0.
REQ-028 Word index wrap-around SHALL be modulo DEPTH. Addresses at or above DEPTH*2 alias with no error.

Reset
REQ-029 While rst_n=0 at an edge: all stage valids, resp_valid, resp_wr, resp_err and inflight SHALL be 0, and resp_rdata SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all in-flight responses. The array contents SHALL NOT be cleared, and no write SHALL occur on a reset edge. req_ready SHALL be 1 on the first cycle after reset release.

Configuration
REQ-031 With MEM_ALIGN_CHECK_EN defined: a request with req_addr[0]=1 SHALL be accepted but leave the array unchanged, and its response SHALL carry resp_err=1 and resp_rdata=0.
REQ-032 Without MEM_ALIGN_CHECK_EN: req_addr[0] SHALL be ignored, and resp_err SHALL be tied 0.

Structure
REQ-033 Package mem_pkg SHALL hold the ADDR_W/DATA_W/LATENCY defaults and a packed stage typedef mem_stage_t {valid, wr, err, data}.
REQ-034 The storage SHALL be a sub-module mem_array (single port: synchronous write, combinational read, no reset of contents). The pipeline and handshake SHALL live in mem_responder.

Verification
REQ-035 Reset, then write 0x1234 to addr 0x0010, then read 0x0010 on the next cycle (resp_ready=1): first response has resp_wr=1 and resp_rdata=0 at acceptance+4; second response has resp_rdata=0x1234 one cycle later.
REQ-036 Back-to-back reads of addrs 0x0000..0x000E (8 requests) with resp_ready=1: 8 consecutive responses in order, req_ready constantly 1, inflight peaks at 4.
REQ-037 Hold resp_ready=0 for 5 cycles after the first response appears: resp_rdata stable, req_ready=0, inflight=4. On release, the remaining responses drain one per cycle.
REQ-038 Assert rst_n=0 for one edge with 3 reads in flight: resp_valid=0 and inflight=0 next cycle. A previously written value is still read back afterwards.
REQ-039 MEM_ALIGN_CHECK_EN defined, write 0xBEEF to 0x0021, then read 0x0020: write response has resp_err=1; read returns the old contents with resp_err=0. Without the macro, the read returns 0xBEEF.
REQ-040 Write 0xAAAA to addr 0x0000 with DEPTH=1024, then read 0x0800: read returns 0xAAAA (wrap-around).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared defaults and the pipeline stage record for the memory responder.
package mem_pkg;

  localparam int MEM_ADDR_W  = 16;
  localparam int MEM_DATA_W  = 16;
  localparam int MEM_LATENCY = 4;
  localparam int MEM_DEPTH   = 1024;

  // The data field is MEM_DATA_W wide, so instances must keep DATA_W at this width.
  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  err;
    logic [MEM_DATA_W-1:0] data;
  } mem_stage_t;

endpackage

// File: rtl/mem_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
interface mem_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  // valid/ready: a beat transfers on a rising edge where both are 1. Once
  // resp_valid is raised, resp_* stay stable until resp_ready takes the beat.
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_wr;
  logic              resp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_wr, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_wr, resp_err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port word store: synchronous write, combinational read, contents never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH  = MEM_DEPTH,
  parameter int DATA_W = MEM_DATA_W,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: LATENCY-deep response pipeline that freezes on backpressure.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int DEPTH   = MEM_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_if.slave       bus,
  output logic [2:0] inflight
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_stage_t        stage [LATENCY];
  mem_stage_t        new_stage;
  logic              resp_v;
  logic              stall;
  logic              accept;
  logic              consume;
  logic              misaligned;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  assign resp_v  = stage[LATENCY-1].valid;
  assign stall   = resp_v & ~bus.resp_ready;
  assign accept  = bus.req_valid & ~stall & rst_n;
  assign consume = resp_v & bus.resp_ready;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = bus.req_addr[0];
`else
  assign misaligned = 1'b0;
`endif

  assign idx    = IDX_W'(32'(bus.req_addr[ADDR_W-1:1]) % DEPTH);
  assign mem_we = accept & bus.req_wr & ~misaligned;

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx),
    .wdata (bus.req_wdata),
    .rdata (rd_word)
  );

  // Read data is captured at acceptance; writes and misaligned requests carry zero.
  always_comb begin
    new_stage = '0;
    if (accept) begin
      new_stage.valid = 1'b1;
      new_stage.wr    = bus.req_wr;
      new_stage.err   = misaligned;
      new_stage.data  = (bus.req_wr || misaligned) ? '0 : MEM_DATA_W'(rd_word);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else if (!stall) begin
      stage[0] <= new_stage;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (accept && !consume && inflight != 3'(LATENCY)) begin
      inflight <= inflight + 3'd1;
    end else if (!accept && consume && inflight != 3'd0) begin
      inflight <= inflight - 3'd1;
    end
  end

  always_comb begin
    bus.req_ready  = ~stall;
    bus.resp_valid = resp_v;
    bus.resp_wr    = resp_v & stage[LATENCY-1].wr;
    bus.resp_err   = resp_v & stage[LATENCY-1].err;
    bus.resp_rdata = resp_v ? DATA_W'(stage[LATENCY-1].data) : '0;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with the default parameters.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int LAT = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int DEP = 1024;

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic          EXP_ALIGN_ERR = 1'b1;
  localparam logic [DW-1:0] EXP_ALIGN_RD  = 16'h5555;
`else
  localparam logic          EXP_ALIGN_ERR = 1'b0;
  localparam logic [DW-1:0] EXP_ALIGN_RD  = 16'hBEEF;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] inflight;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_responder #(.LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .inflight (inflight)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected queue plus the responses observed being consumed
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cap_data[$];
  logic          cap_wr[$];
  logic          cap_err[$];
  int            cap_cyc[$];

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      cap_data.push_back(bus.resp_rdata);
      cap_wr.push_back(bus.resp_wr);
      cap_err.push_back(bus.resp_err);
      cap_cyc.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_wr.delete();
    cap_err.delete();
    cap_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.resp_ready = 1'b1;
    repeat (3) tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    checks++; if (bus.resp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", bus.resp_rdata); end
    checks++; if (bus.resp_wr !== 1'b0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got wr=%b err=%b want 0/0", bus.resp_wr, bus.resp_err); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write_read();
    clear_caps();
    drive_req(1'b1, 16'h0010, 16'h1234);
    tick();
    drive_req(1'b0, 16'h0010, 16'h0000);
    tick();
    idle();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_early1: got resp_valid=%b want 0", bus.resp_valid); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_early2: got resp_valid=%b want 0", bus.resp_valid); end
    tick();
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_wr !== 1'b1 || bus.resp_rdata !== 16'h0000) begin errors++; $display("FAIL wr_resp: got v=%b wr=%b rdata=%h want 1/1/0000", bus.resp_valid, bus.resp_wr, bus.resp_rdata); end
    checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL wr_rd_inflight: got %0d want 2", inflight); end
    tick();
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_wr !== 1'b0 || bus.resp_rdata !== 16'h1234 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL rd_resp: got v=%b wr=%b err=%b rdata=%h want 1/0/0/1234", bus.resp_valid, bus.resp_wr, bus.resp_err, bus.resp_rdata); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 16'h0000 || inflight !== 3'd0) begin errors++; $display("FAIL wr_rd_drain: got v=%b rdata=%h inflight=%0d want 0/0000/0", bus.resp_valid, bus.resp_rdata, inflight); end
  endtask

  task automatic test_back_to_back();
    int ready_low;
    logic [2:0] peak;
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b1, 16'(2 * i), 16'hA000 + 16'(i));
      tick();
    end
    idle();
    repeat (8) tick();
    clear_caps();
    ready_low = 0;
    peak = '0;
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b0, 16'(2 * i), 16'h0000);
      exp_q.push_back(16'hA000 + 16'(i));
      #1;
      if (bus.req_ready !== 1'b1) ready_low++;
      tick();
      if (inflight > peak) peak = inflight;
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (inflight > peak) peak = inflight;
    end
    checks++; if (cap_data.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", cap_data.size()); end
    for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
      checks++; if (cap_data[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, cap_data[i], exp_q[i]); end
    end
    checks++; if (ready_low != 0) begin errors++; $display("FAIL b2b_ready: got %0d low cycles want 0", ready_low); end
    checks++; if (peak !== 3'd4) begin errors++; $display("FAIL b2b_peak_inflight: got %0d want 4", peak); end
    if (cap_cyc.size() == 8) begin
      checks++; if (cap_cyc[7] - cap_cyc[0] != 7) begin errors++; $display("FAIL b2b_consecutive: got span %0d want 7", cap_cyc[7] - cap_cyc[0]); end
    end
  endtask

  task automatic test_stall();
    int sent;
    int stall_left;
    int stall_cyc;
    logic [DW-1:0] held;
    clear_caps();
    sent = 0;
    stall_left = -1;
    stall_cyc = 0;
    held = '0;
    for (int c = 0; c < 60 && cap_data.size() < 8; c++) begin
      if (bus.resp_valid && stall_left < 0) begin
        stall_left = 5;
        held = bus.resp_rdata;
        stall_cyc = cyc;
      end
      bus.resp_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      if (sent < 8) drive_req(1'b0, 16'(2 * sent), 16'h0000);
      else idle();
      #1;
      if (stall_left > 0) begin
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", bus.req_ready); end
        checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL stall_inflight: got %0d want 4", inflight); end
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== held) begin errors++; $display("FAIL stall_hold: got v=%b rdata=%h want 1/%h", bus.resp_valid, bus.resp_rdata, held); end
      end
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(16'hA000 + 16'(sent));
        sent++;
      end
      tick();
      if (stall_left > 0) stall_left--;
    end
    bus.resp_ready = 1'b1;
    idle();
    checks++; if (stall_left != 0) begin errors++; $display("FAIL stall_seen: got stall_left=%0d want 0", stall_left); end
    checks++; if (cap_data.size() != 8) begin errors++; $display("FAIL stall_count: got %0d want 8", cap_data.size()); end
    for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
      checks++; if (cap_data[i] !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", i, cap_data[i], 16'hA000 + 16'(i)); end
    end
    if (cap_cyc.size() == 8) begin
      checks++; if (cap_cyc[0] != stall_cyc + 5) begin errors++; $display("FAIL stall_release: got cyc %0d want %0d", cap_cyc[0], stall_cyc + 5); end
      checks++; if (cap_cyc[7] - cap_cyc[0] != 7) begin errors++; $display("FAIL stall_drain: got span %0d want 7", cap_cyc[7] - cap_cyc[0]); end
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_midflight();
    clear_caps();
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, 16'h0010, 16'h0000);
      tick();
    end
    drive_req(1'b1, 16'h0010, 16'hDEAD);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    checks++; if (bus.resp_valid !== 1'b0 || inflight !== 3'd0) begin errors++; $display("FAIL midreset_clear: got v=%b inflight=%0d want 0/0", bus.resp_valid, inflight); end
    repeat (6) tick();
    checks++; if (cap_data.size() != 0) begin errors++; $display("FAIL midreset_discard: got %0d responses want 0", cap_data.size()); end
    drive_req(1'b0, 16'h0010, 16'h0000);
    tick();
    idle();
    repeat (6) tick();
    checks++; if (cap_data.size() != 1 || cap_data[0] !== 16'h1234) begin errors++; $display("FAIL midreset_keep: got n=%0d rdata=%h want 1/1234", cap_data.size(), cap_data[0]); end
  endtask

  task automatic test_align();
    clear_caps();
    drive_req(1'b1, 16'h0020, 16'h5555);
    tick();
    drive_req(1'b1, 16'h0021, 16'hBEEF);
    tick();
    drive_req(1'b0, 16'h0020, 16'h0000);
    tick();
    idle();
    repeat (8) tick();
    checks++; if (cap_data.size() != 3) begin errors++; $display("FAIL align_count: got %0d want 3", cap_data.size()); end
    if (cap_data.size() == 3) begin
      checks++; if (cap_err[1] !== EXP_ALIGN_ERR || cap_wr[1] !== 1'b1 || cap_data[1] !== 16'h0000) begin errors++; $display("FAIL align_wr_resp: got err=%b wr=%b rdata=%h want %b/1/0000", cap_err[1], cap_wr[1], cap_data[1], EXP_ALIGN_ERR); end
      checks++; if (cap_data[2] !== EXP_ALIGN_RD || cap_err[2] !== 1'b0 || cap_wr[2] !== 1'b0) begin errors++; $display("FAIL align_rd_resp: got rdata=%h err=%b wr=%b want %h/0/0", cap_data[2], cap_err[2], cap_wr[2], EXP_ALIGN_RD); end
      checks++; if (cap_err[0] !== 1'b0) begin errors++; $display("FAIL align_ok_err: got %b want 0", cap_err[0]); end
    end
  endtask

  task automatic test_wrap();
    clear_caps();
    drive_req(1'b1, 16'h0000, 16'hAAAA);
    tick();
    drive_req(1'b0, 16'h0800, 16'h0000);
    tick();
    drive_req(1'b0, 16'h4800, 16'h0000);
    tick();
    idle();
    repeat (8) tick();
    checks++; if (cap_data.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d want 3", cap_data.size()); end
    if (cap_data.size() == 3) begin
      checks++; if (cap_data[1] !== 16'hAAAA || cap_err[1] !== 1'b0) begin errors++; $display("FAIL wrap_0800: got rdata=%h err=%b want AAAA/0", cap_data[1], cap_err[1]); end
      checks++; if (cap_data[2] !== 16'hAAAA || cap_err[2] !== 1'b0) begin errors++; $display("FAIL wrap_4800: got rdata=%h err=%b want AAAA/0", cap_data[2], cap_err[2]); end
    end
  endtask

  initial begin
    idle();
    bus.resp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_align();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
